// File: rtl/vend_ctrl_fsm_if.sv
// Bus between the vending controller and its surroundings: coin/selection
// inputs, dispenser handshakes and the status/credit outputs.
interface vend_ctrl_fsm_if;
  // Dispenser handshake: the controller holds *_dispense_req high (level) with
  // product_sel / change_amount stable; the unit answers with a one-cycle
  // *_dispense_done, and req drops on the following edge. A done seen while
  // the matching req is low carries no meaning and is ignored.
  logic       coin_valid;
  logic [7:0] coin_value;
  logic       select_valid;
  logic [1:0] product_id;
  logic       cancel;
  logic       product_dispense_done;
  logic       change_dispense_done;
  logic [2:0] state_out;
  logic       display_status_en;
  logic       product_dispense_req;
  logic [1:0] product_sel;
  logic       change_dispense_req;
  logic [7:0] change_amount;
  logic [7:0] credit;
  logic       coin_reject;
  logic       insufficient;

  modport slave (
    input  coin_valid, coin_value, select_valid, product_id, cancel,
           product_dispense_done, change_dispense_done,
    output state_out, display_status_en, product_dispense_req, product_sel,
           change_dispense_req, change_amount, credit, coin_reject, insufficient
  );

  modport master (
    output coin_valid, coin_value, select_valid, product_id, cancel,
           product_dispense_done, change_dispense_done,
    input  state_out, display_status_en, product_dispense_req, product_sel,
           change_dispense_req, change_amount, credit, coin_reject, insufficient
  );
endinterface

// File: rtl/vend_ctrl_fsm.sv
// Vending machine sequencing controller: credit accumulation, price check,
// and product / change dispenser handoff. Every output is a register.
module vend_ctrl_fsm #(
  parameter int unsigned PRICE0     = 10,
  parameter int unsigned PRICE1     = 15,
  parameter int unsigned PRICE2     = 20,
  parameter int unsigned PRICE3     = 25,
  parameter int unsigned MAX_CREDIT = 100,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  vend_ctrl_fsm_if.slave  ctrl_if
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE            = 3'b000,
    S_WAIT_COIN       = 3'b001,
    S_SELECT_PRODUCT  = 3'b010,
    S_DISPENSE_CHANGE = 3'b011,
    S_RETURN_MONEY    = 3'b100
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    credit_q, credit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    psel_q, psel_d;
  logic [7:0]    camt_q, camt_d;
  logic          preq_q, preq_d;
  logic          creq_q, creq_d;
  logic          rej_q, rej_d;
  logic          ins_q, ins_d;
  logic          disp_en_q;

  logic [8:0] sum9;
  logic       coin_ok;
  logic [7:0] price;

  function automatic logic [7:0] price_of(input logic [1:0] id);
    case (id)
      2'd0:    return 8'(PRICE0);
      2'd1:    return 8'(PRICE1);
      2'd2:    return 8'(PRICE2);
      default: return 8'(PRICE3);
    endcase
  endfunction

  // Sum is one bit wider so an overflowing coin is caught, not wrapped.
  assign sum9    = {1'b0, credit_q} + {1'b0, ctrl_if.coin_value};
  assign coin_ok = ctrl_if.coin_valid && (ctrl_if.coin_value != 8'd0) &&
                   (sum9 <= 9'(MAX_CREDIT));
  assign price   = price_of(ctrl_if.product_id);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      credit_q  <= '0;
      cnt_q     <= '0;
      psel_q    <= '0;
      camt_q    <= '0;
      preq_q    <= 1'b0;
      creq_q    <= 1'b0;
      rej_q     <= 1'b0;
      ins_q     <= 1'b0;
      disp_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      cnt_q     <= cnt_d;
      psel_q    <= psel_d;
      camt_q    <= camt_d;
      preq_q    <= preq_d;
      creq_q    <= creq_d;
      rej_q     <= rej_d;
      ins_q     <= ins_d;
      disp_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    cnt_d    = cnt_q;
    psel_d   = psel_q;
    camt_d   = camt_q;
    preq_d   = preq_q;
    creq_d   = creq_q;
    rej_d    = 1'b0;
    ins_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (coin_ok) begin
          credit_d = sum9[7:0];
          cnt_d    = '0;
          state_d  = S_WAIT_COIN;
        end else begin
          rej_d = ctrl_if.coin_valid;
        end
      end

      S_WAIT_COIN: begin
        if (ctrl_if.cancel) begin
          state_d = S_RETURN_MONEY;
          rej_d   = ctrl_if.coin_valid;
          creq_d  = (credit_q != 8'd0);
          camt_d  = credit_q;
        end else if (ctrl_if.select_valid && (credit_q >= price)) begin
          state_d  = S_SELECT_PRODUCT;
          credit_d = credit_q - price;
          psel_d   = ctrl_if.product_id;
          preq_d   = 1'b1;
          rej_d    = ctrl_if.coin_valid;
        end else begin
          if (ctrl_if.select_valid) begin
            ins_d = 1'b1;
            cnt_d = '0;
          end
          if (coin_ok) begin
            credit_d = sum9[7:0];
            cnt_d    = '0;
          end else begin
            rej_d = ctrl_if.coin_valid;
            // A rejected coin is not activity, so the idle timer keeps running.
            if (!ctrl_if.select_valid) begin
              if (cnt_q == CW'(TIMEOUT - 1)) begin
                state_d = S_RETURN_MONEY;
                creq_d  = (credit_q != 8'd0);
                camt_d  = credit_q;
              end else begin
                cnt_d = cnt_q + CW'(1);
              end
            end
          end
        end
      end

      S_SELECT_PRODUCT: begin
        rej_d = ctrl_if.coin_valid;
        if (preq_q && ctrl_if.product_dispense_done) begin
          preq_d = 1'b0;
          if (credit_q == 8'd0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DISPENSE_CHANGE;
            creq_d  = 1'b1;
            camt_d  = credit_q;
          end
        end
      end

      S_DISPENSE_CHANGE, S_RETURN_MONEY: begin
        rej_d = ctrl_if.coin_valid;
        if (!creq_q) begin
          state_d = S_IDLE;
        end else if (ctrl_if.change_dispense_done) begin
          creq_d   = 1'b0;
          credit_d = '0;
          camt_d   = '0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        // Corrupted state code: drop everything and restart clean.
        state_d  = S_IDLE;
        credit_d = '0;
        cnt_d    = '0;
        camt_d   = '0;
        preq_d   = 1'b0;
        creq_d   = 1'b0;
        rej_d    = ctrl_if.coin_valid;
      end
    endcase
  end

  assign ctrl_if.state_out            = state_q;
  assign ctrl_if.display_status_en    = disp_en_q;
  assign ctrl_if.product_dispense_req = preq_q;
  assign ctrl_if.product_sel          = psel_q;
  assign ctrl_if.change_dispense_req  = creq_q;
  assign ctrl_if.change_amount        = camt_q;
  assign ctrl_if.credit               = credit_q;
  assign ctrl_if.coin_reject          = rej_q;
  assign ctrl_if.insufficient         = ins_q;

endmodule
